// File: rtl/dmem_store_responder.sv
// Data-memory responder: 16-bit big-endian stores are queued in a small buffer and drained
// into a byte-addressed array one byte per cycle, with byte-granular load forwarding.
module dmem_store_responder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr_en_in,
  input  logic [ADDR_W-1:0] alu_out_in,
  input  logic [15:0]       data_in,
  output logic [15:0]       mem_read_val,
  output logic              stall,
  output logic              buf_empty,
  output logic [CntW-1:0]   buf_count
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned MemSize = 2 ** ADDR_W;

  typedef enum logic {PhHi, PhLo} phase_e;

  phase_e            phase_q, phase_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [15:0]       ent_data_q [DEPTH];
  logic [7:0]        mem_q [MemSize];

  logic              push, pop, draining;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] ld_lo_addr;
  logic [7:0]        rd_hi, rd_lo;

  assign stall     = mem_wr_en_in & (count_q == CntW'(DEPTH));
  assign push      = mem_wr_en_in & ~stall;
  assign draining  = (count_q != '0);
  assign pop       = draining & (phase_q == PhLo);
  assign buf_empty = (count_q == '0);
  assign buf_count = count_q;

  always_comb begin
    phase_d = phase_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (draining) begin
      phase_d = (phase_q == PhHi) ? PhLo : PhHi;
    end
    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PhHi;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset: validity is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= alu_out_in;
      ent_data_q[tail_q] <= data_in;
    end
  end

  always_comb begin
    mem_we    = draining;
    mem_waddr = ent_addr_q[head_q];
    mem_wdata = ent_data_q[head_q][15:8];
    if (phase_q == PhLo) begin
      mem_waddr = ent_addr_q[head_q] + ADDR_W'(1);
      mem_wdata = ent_data_q[head_q][7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ld_lo_addr = alu_out_in + ADDR_W'(1);

  // Walk entries oldest to newest so the newest covering entry wins for each byte.
  always_comb begin
    rd_hi = mem_q[alu_out_in];
    rd_lo = mem_q[ld_lo_addr];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      logic [PtrW-1:0]   idx;
      logic [ADDR_W-1:0] e_hi, e_lo;
      idx  = head_q + PtrW'(k);
      e_hi = ent_addr_q[idx];
      e_lo = ent_addr_q[idx] + ADDR_W'(1);
      if (CntW'(k) < count_q) begin
        if (e_hi == alu_out_in) begin
          rd_hi = ent_data_q[idx][15:8];
        end else if (e_lo == alu_out_in) begin
          rd_hi = ent_data_q[idx][7:0];
        end
        if (e_hi == ld_lo_addr) begin
          rd_lo = ent_data_q[idx][15:8];
        end else if (e_lo == ld_lo_addr) begin
          rd_lo = ent_data_q[idx][7:0];
        end
      end
    end
  end

  assign mem_read_val = {rd_hi, rd_lo};

endmodule

// File: tb/tb_dmem_store_responder.sv
// Directed bench for dmem_store_responder: forwarding, wrap, overlap, full buffer, reset.
module tb_dmem_store_responder;

  logic        clk;
  logic        rst;
  logic        mem_wr_en_in;
  logic [15:0] alu_out_in;
  logic [15:0] data_in;
  logic [15:0] mem_read_val;
  logic        stall;
  logic        buf_empty;
  logic [2:0]  buf_count;

  int n_checks = 0;
  int n_errors = 0;

  dmem_store_responder #(
    .DEPTH  (4),
    .ADDR_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wr_en_in (mem_wr_en_in),
    .alu_out_in   (alu_out_in),
    .data_in      (data_in),
    .mem_read_val (mem_read_val),
    .stall        (stall),
    .buf_empty    (buf_empty),
    .buf_count    (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    mem_wr_en_in = 1'b1;
    alu_out_in   = a;
    data_in      = d;
    step();
    mem_wr_en_in = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    alu_out_in = a;
    #1;
    chk(tag, 32'(mem_read_val), 32'(exp));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!buf_empty && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'(buf_empty), 32'd1);
  endtask

  initial begin
    int   idx;
    logic s;

    rst          = 1'b0;
    mem_wr_en_in = 1'b0;
    alu_out_in   = '0;
    data_in      = '0;
    #12;
    chk("reset_count", 32'(buf_count), 32'd0);
    chk("reset_empty", 32'(buf_empty), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    step();

    // Single store and forwarding
    store(16'h0010, 16'h1234);
    chk("single_count", 32'(buf_count), 32'd1);
    load_chk("single_fwd", 16'h0010, 16'h1234);
    step();
    step();
    chk("single_empty", 32'(buf_empty), 32'd1);
    load_chk("single_array", 16'h0010, 16'h1234);
    store(16'h0012, 16'h5678);
    load_chk("single_mixed", 16'h0011, 16'h3456);
    drain("single_drain");

    // Address wrap
    store(16'h0000, 16'h0099);
    drain("wrap_drain0");
    store(16'hFFFF, 16'hABCD);
    load_chk("wrap_ffff_fwd", 16'hFFFF, 16'hABCD);
    load_chk("wrap_0000_fwd", 16'h0000, 16'hCD99);
    drain("wrap_drain1");
    load_chk("wrap_ffff_arr", 16'hFFFF, 16'hABCD);
    load_chk("wrap_0000_arr", 16'h0000, 16'hCD99);

    // Overlapping stores: newest wins per byte
    store(16'h0020, 16'h1111);
    store(16'h0021, 16'h2222);
    for (int i = 0; i < 6 && !buf_empty; i++) begin
      load_chk("overlap_20_pending", 16'h0020, 16'h1122);
      step();
    end
    chk("overlap_empty", 32'(buf_empty), 32'd1);
    load_chk("overlap_20_arr", 16'h0020, 16'h1122);
    load_chk("overlap_21_arr", 16'h0021, 16'h2222);

    // Full buffer: 8 back-to-back stores, stalls expected before edges 7 and 9
    idx = 0;
    for (int e = 1; e <= 10; e++) begin
      mem_wr_en_in = (idx < 8);
      alu_out_in   = 16'(16'h0100 + 4 * idx);
      data_in      = 16'(16'hC000 + 16'h0105 * idx);
      #1;
      s = stall;
      chk($sformatf("burst_stall_e%0d", e), 32'(s), 32'((e == 7) || (e == 9)));
      step();
      if (!s && idx < 8) idx++;
    end
    mem_wr_en_in = 1'b0;
    chk("burst_accepted", 32'(idx), 32'd8);
    drain("burst_drain");
    for (int i = 0; i < 8; i++) begin
      load_chk($sformatf("burst_rd%0d", i), 16'(16'h0100 + 4 * i),
               16'(16'hC000 + 16'h0105 * i));
    end

    // Reset mid-drain: known background first
    store(16'h0210, 16'hEEEE);
    store(16'h0220, 16'hEEEE);
    store(16'h0230, 16'hEEEE);
    drain("rst_bg_drain");
    store(16'h0200, 16'h1A2B);
    store(16'h0210, 16'h3C4D);
    store(16'h0220, 16'h5E6F);
    store(16'h0230, 16'h7081);
    chk("rst_pre_count", 32'(buf_count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_count", 32'(buf_count), 32'd0);
    chk("rst_async_empty", 32'(buf_empty), 32'd1);
    chk("rst_async_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    load_chk("rst_e0", 16'h0200, 16'h1A2B);
    step();
    load_chk("rst_e1_half", 16'h0210, 16'h3CEE);
    load_chk("rst_e2_old", 16'h0220, 16'hEEEE);
    load_chk("rst_e3_old", 16'h0230, 16'hEEEE);
    chk("rst_idle_count", 32'(buf_count), 32'd0);

    // Simultaneous push and pop
    store(16'h0310, 16'hEEEE);
    drain("pp_bg_drain");
    store(16'h0300, 16'h1111);
    store(16'h0310, 16'h2233);
    chk("pp_count_before", 32'(buf_count), 32'd2);
    store(16'h0320, 16'h4455);
    chk("pp_count_after", 32'(buf_count), 32'd2);
    step();
    #1;
    rst = 1'b0;
    load_chk("pp_head_hi", 16'h0310, 16'h22EE);
    load_chk("pp_popped", 16'h0300, 16'h1111);
    rst = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_store_responder.md
# dmem_store_responder

Data-memory responder on the far side of the CPU MEM-stage store/load interface. It accepts 16-bit stores into a small store buffer and drains them into an internal byte-wide, byte-addressed array one byte per cycle. Loads are answered combinationally, with byte-granular forwarding from buffered stores. Back-pressure is applied through `stall`, which feeds the pipeline freeze logic.

## Interface
Parameters:
- DEPTH, 4, store-buffer entries (power of two, ≥2)
- ADDR_W, 16, byte-address width; array holds 2^ADDR_W bytes

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_wr_en_in  in  1  store request from the MEM stage
- alu_out_in  in  ADDR_W  byte address for the load or store
- data_in  in  16  store data
- mem_read_val  out  16  load data for `alu_out_in`; combinational
- stall  out  1  store not accepted this cycle; CPU must hold the request
- buf_empty  out  1  no stores pending
- buf_count  out  $clog2(DEPTH)+1  pending entry count

## Operation
- Byte order is big-endian. A store of D at address A writes D[15:8] to byte A and D[7:0] to byte A+1.
- A+1 is computed modulo 2^ADDR_W. Unaligned addresses are legal.
- Store acceptance: a store is accepted at a clock edge when `mem_wr_en_in & ~stall`. On acceptance, {A, D} is pushed at the tail.
- `stall = mem_wr_en_in & (buf_count == DEPTH)`. Stall stays asserted even if a pop happens on the same edge; the store is accepted on the next edge.
- Drain engine: a 1-bit phase register with states HI and LO.
  - While `buf_count > 0`, each edge writes one byte of the head entry.
  - In phase HI, it writes D[15:8] to byte A, then moves to LO.
  - In phase LO, it writes D[7:0] to byte A+1, pops the head, then returns to HI.
  - While `buf_count == 0`, phase stays HI and no array write occurs.
- Push and pop on the same edge leave `buf_count` unchanged. Pointers wrap modulo DEPTH.
- Loads: `mem_read_val[15:8]` is byte `alu_out_in` and `mem_read_val[7:0]` is byte `alu_out_in+1`. Each byte is resolved independently:
  - If any buffered entry, including the head being drained, covers that byte address, the newest such entry's byte is used.
  - Otherwise the array byte is used.
- Loads are never stalled. `mem_read_val` is driven every cycle regardless of `mem_wr_en_in`.
- A store presented in the current cycle is not forwarded to a load in the same cycle. It is visible from the cycle after acceptance.
- Array contents are not reset.

## Timing
- Reset (asynchronous, rst=0):
  - `buf_count=0`, `buf_empty=1`, `stall=0`, phase HI, head and tail pointers 0.
  - Pending entries are discarded.
  - Bytes already written to the array persist.
- Store accepted at edge N:
  - Visible to loads from the cycle after edge N.
  - Byte A is written at edge N+1 and byte A+1 at edge N+2, provided the buffer was empty at N.
  - The entry pops at N+2, so `buf_empty` rises after N+2.
- Sustained throughput is one store per 2 cycles. The buffer absorbs bursts of up to DEPTH+⌊DEPTH/2⌋ back-to-back stores without a stall.
- Reset deasserting mid-cycle leaves the engine idle. The first drain write occurs on the edge after the first post-reset acceptance.

## Test plan
- **Single store and forwarding:** After reset, store 0x1234 at 0x0010 at edge 1.
  - In the cycle after edge 1, a load at 0x0010 returns 0x1234 from forwarding.
  - After edge 3: `buf_empty=1` and a load at 0x0010 still returns 0x1234.
  - Store 0x5678 at 0x0012, then a load at 0x0011 returns 0x3456.
- **Address wrap:** Store 0x0099 at 0x0000, let it drain, then store 0xABCD at 0xFFFF.
  - Load 0xFFFF returns 0xABCD.
  - Load 0x0000 returns 0xCD99, both before and after the buffer drains.
- **Overlapping stores:** Store 0x1111 at 0x0020 and 0x2222 at 0x0021 on consecutive edges.
  - Load 0x0020 returns 0x1122 at every cycle until drained and after draining (newest wins).
  - Load 0x0021 returns 0x2222.
- **Full buffer (DEPTH=4):** Present 8 stores back-to-back starting at edge 1.
  - Stores 1–6 are accepted at edges 1–6.
  - Store 7 sees `stall=1` in the cycle before edge 7 and is accepted at edge 8.
  - Store 8 is stalled before edge 9 and accepted at edge 10.
  - All 8 words read back correctly after `buf_empty=1`.
- **Reset mid-drain:** With 3 entries pending and entry 1 half-written, drive rst=0 asynchronously.
  - `buf_count=0`, `buf_empty=1` and `stall=0` immediately, without waiting for a clock edge.
  - The high byte of entry 1 is in the array; the other pending bytes are unchanged.
- **Simultaneous push and pop:** With `buf_count=2` and phase LO, a store is accepted at an edge.
  - `buf_count` stays 2.
  - The next edge writes the new head's high byte.
